// File: rtl/rx_sample_fifo_if.sv
// Bus between the DDC/CPU side and the receive sample FIFO.
// The CPU side drives the master modport and the FIFO takes the slave modport.
interface rx_sample_fifo_if;
  logic        samp_wr;
  logic [15:0] samp_din;
  logic [15:0] op;
  logic        wrEvt;
  logic        rdReg;
  logic        hb_orst;
  logic        rx_rd;
  logic [15:0] rx_dout;
  logic [15:0] cnt_dout;
  logic        rx_rdy;
  logic        hb_ovfl;

  modport master (
    output samp_wr, samp_din, op, wrEvt, rdReg, hb_orst,
    input  rx_rd, rx_dout, cnt_dout, rx_rdy, hb_ovfl
  );

  modport slave (
    input  samp_wr, samp_din, op, wrEvt, rdReg, hb_orst,
    output rx_rd, rx_dout, cnt_dout, rx_rdy, hb_ovfl
  );
endinterface

// File: rtl/rx_sample_fifo.sv
// Receive sample FIFO ahead of the host bridge: buffers DDC words and serves them on get-sample events.
// A synchronous-read RAM is combined with a prefetched head register, which gives first-word-fall-through output.
module rx_sample_fifo #(
  parameter int unsigned DEPTH  = 2048,
  parameter int unsigned THRESH = 1024,
  parameter int unsigned OP_GET = 0,
  parameter int unsigned OP_CNT = 1
) (
  input  logic              hb_clk,
  input  logic              hb_rst,
  rx_sample_fifo_if.slave   bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] THR_CNT  = CW'(THRESH);

  typedef enum logic [1:0] {EMPTY, FETCH, HEAD} state_t;

  state_t        state_q, state_d;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic [15:0]   head_q;
  logic          head_v;
  logic          unfl, ovfl_q, rdy_q;
  logic          pop_req, cnt_rd, pop_ok, push_ok;
  logic          ovfl_evt, unfl_evt, ram_avail, load_head;
  logic [15:0]   cnt_word;

  assign head_v    = (state_q == HEAD);
  assign load_head = (state_q == FETCH);
  assign pop_req   = bus.wrEvt & bus.op[OP_GET];
  assign cnt_rd    = bus.rdReg & bus.op[OP_CNT];
  assign pop_ok    = pop_req & head_v;
  // A pop of a valid head frees a slot, so a push into a full FIFO can still land.
  assign push_ok   = bus.samp_wr & ((cnt != FULL_CNT) | pop_ok);
  assign ovfl_evt  = bus.samp_wr & ~push_ok;
  assign unfl_evt  = pop_req & ~head_v;

  // The RAM holds words beyond the head, including any push arriving this cycle.
  assign ram_avail = push_ok | (cnt > CW'(head_v));

  always_ff @(posedge hb_clk or posedge hb_rst) begin
    if (hb_rst) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (ram_avail) state_d = FETCH;
      FETCH:   state_d = HEAD;
      HEAD:    if (pop_ok) state_d = ram_avail ? FETCH : EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Sample storage; contents are not cleared on reset.
  always_ff @(posedge hb_clk) begin
    if (push_ok) mem[wp] <= bus.samp_din;
  end

  always_ff @(posedge hb_clk or posedge hb_rst) begin
    if (hb_rst) begin
      wp     <= '0;
      rp     <= '0;
      cnt    <= '0;
      head_q <= '0;
      ovfl_q <= 1'b0;
      unfl   <= 1'b0;
      rdy_q  <= 1'b0;
    end else begin
      if (push_ok) wp <= wp + AW'(1);
      if (load_head) begin
        head_q <= mem[rp];
        rp     <= rp + AW'(1);
      end
      cnt    <= cnt + CW'(push_ok) - CW'(pop_ok);
      ovfl_q <= ovfl_evt | (ovfl_q & ~bus.hb_orst);
      unfl   <= unfl_evt | (unfl & ~cnt_rd);
      rdy_q  <= (cnt >= THR_CNT);
    end
  end

  // Status word is zero outside its op so it can be OR-ed onto the CPU bus.
  always_comb begin
    cnt_word         = '0;
    cnt_word[15]     = unfl;
    cnt_word[14]     = ovfl_q;
    cnt_word[CW-1:0] = cnt;
  end

  assign bus.rx_rd    = pop_req;
  assign bus.rx_dout  = head_v ? head_q : 16'h0000;
  assign bus.cnt_dout = cnt_rd ? cnt_word : 16'h0000;
  assign bus.rx_rdy   = rdy_q;
  assign bus.hb_ovfl  = ovfl_q;

endmodule

// File: tb/tb_rx_sample_fifo.sv
// Scoreboard bench for rx_sample_fifo: expected words are queued on push and compared on pop.
module tb_rx_sample_fifo;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned THRESH = 4;
  localparam int unsigned OP_GET = 0;
  localparam int unsigned OP_CNT = 1;

  logic hb_clk = 1'b0;
  logic hb_rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic exp_ovfl = 1'b0;
  logic [15:0] sb [$];

  rx_sample_fifo_if bus ();

  rx_sample_fifo #(
    .DEPTH (DEPTH),
    .THRESH(THRESH),
    .OP_GET(OP_GET),
    .OP_CNT(OP_CNT)
  ) dut (
    .hb_clk(hb_clk),
    .hb_rst(hb_rst),
    .bus   (bus)
  );

  always #5 hb_clk = ~hb_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge hb_clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w);
    bus.samp_wr  = 1'b1;
    bus.samp_din = w;
    if (sb.size() < DEPTH) sb.push_back(w);
    else exp_ovfl = 1'b1;
    cyc();
    bus.samp_wr = 1'b0;
  endtask

  task automatic pop(input string tag);
    logic [15:0] exp;
    bus.wrEvt = 1'b1;
    bus.op    = 16'(1 << OP_GET);
    #2;
    check({tag, "_rd"}, 32'(bus.rx_rd), 32'd1);
    exp = 16'h0000;
    if (sb.size() > 0) exp = sb.pop_front();
    check(tag, 32'(bus.rx_dout), 32'(exp));
    cyc();
    bus.wrEvt = 1'b0;
    bus.op    = 16'h0000;
    cyc();
  endtask

  task automatic push_pop(input string tag, input logic [15:0] w);
    logic [15:0] exp;
    bus.wrEvt    = 1'b1;
    bus.op       = 16'(1 << OP_GET);
    bus.samp_wr  = 1'b1;
    bus.samp_din = w;
    #2;
    exp = 16'h0000;
    if (sb.size() > 0) exp = sb.pop_front();
    check(tag, 32'(bus.rx_dout), 32'(exp));
    sb.push_back(w);
    cyc();
    bus.wrEvt   = 1'b0;
    bus.op      = 16'h0000;
    bus.samp_wr = 1'b0;
    cyc();
  endtask

  task automatic read_cnt(input string tag, input logic [15:0] exp);
    bus.rdReg = 1'b1;
    bus.op    = 16'(1 << OP_CNT);
    #2;
    check(tag, 32'(bus.cnt_dout), 32'(exp));
    cyc();
    bus.rdReg = 1'b0;
    bus.op    = 16'h0000;
  endtask

  task automatic drain(input string tag, input int n);
    for (int i = 0; i < n; i++) pop($sformatf("%s%0d", tag, i));
  endtask

  initial begin
    bus.samp_wr  = 1'b0;
    bus.samp_din = 16'h0000;
    bus.op       = 16'h0000;
    bus.wrEvt    = 1'b0;
    bus.rdReg    = 1'b0;
    bus.hb_orst  = 1'b0;
    repeat (2) cyc();
    hb_rst = 1'b0;
    cyc();

    check("rst_dout", 32'(bus.rx_dout),  32'h0);
    check("rst_cnt",  32'(bus.cnt_dout), 32'h0);
    check("rst_rdy",  32'(bus.rx_rdy),   32'h0);
    check("rst_ovfl", 32'(bus.hb_ovfl),  32'h0);
    check("rst_rd",   32'(bus.rx_rd),    32'h0);

    // Basic ordering
    for (int i = 0; i < 4; i++) push(16'(16'h1000 + i));
    repeat (2) cyc();
    read_cnt("cnt4", 16'h0004);
    check("rdy4", 32'(bus.rx_rdy), 32'h1);
    drain("basic", 4);
    read_cnt("cnt_basic_end", 16'h0000);
    check("rdy0", 32'(bus.rx_rdy), 32'h0);

    // Overflow on the 17th push, then clear and drain
    for (int i = 0; i < 17; i++) begin
      push(16'(16'h2000 + i));
      if (i == 15) check("ovfl_at16", 32'(bus.hb_ovfl), 32'h0);
    end
    check("ovfl_set", 32'(bus.hb_ovfl), 32'(exp_ovfl));
    read_cnt("cnt_full", 16'h4010);
    bus.hb_orst = 1'b1;
    cyc();
    bus.hb_orst = 1'b0;
    exp_ovfl = 1'b0;
    check("ovfl_clr", 32'(bus.hb_ovfl), 32'h0);
    drain("ovf", 16);
    read_cnt("cnt_ovf_end", 16'h0000);

    // Simultaneous push and pop while full
    for (int i = 0; i < 16; i++) push(16'(16'h3000 + i));
    repeat (2) cyc();
    push_pop("full_pp", 16'hBEEF);
    check("full_pp_ovfl", 32'(bus.hb_ovfl), 32'h0);
    read_cnt("cnt_full_pp", 16'h0010);
    check("last_is_beef", 32'(sb[sb.size()-1]), 32'hBEEF);
    drain("fpp", 16);
    read_cnt("cnt_fpp_end", 16'h0000);

    // Underflow
    pop("unfl");
    read_cnt("cnt_unfl", 16'h8000);
    read_cnt("cnt_unfl_clr", 16'h0000);

    // Ready threshold
    for (int i = 0; i < 3; i++) push(16'(16'h4000 + i));
    repeat (2) cyc();
    check("rdy_3", 32'(bus.rx_rdy), 32'h0);
    push(16'h4003);
    check("rdy_4_early", 32'(bus.rx_rdy), 32'h0);
    cyc();
    check("rdy_4", 32'(bus.rx_rdy), 32'h1);
    pop("thr_pop");
    check("rdy_after_pop", 32'(bus.rx_rdy), 32'h0);

    // Reset with contents held
    push(16'h4004);
    push(16'h4005);
    repeat (2) cyc();
    hb_rst = 1'b1;
    cyc();
    hb_rst = 1'b0;
    sb.delete();
    exp_ovfl = 1'b0;
    check("mrst_dout", 32'(bus.rx_dout),  32'h0);
    check("mrst_rdy",  32'(bus.rx_rdy),   32'h0);
    check("mrst_ovfl", 32'(bus.hb_ovfl),  32'h0);
    check("mrst_cnt",  32'(bus.cnt_dout), 32'h0);
    read_cnt("mrst_cntrd", 16'h0000);
    push(16'h5000);
    push(16'h5001);
    repeat (2) cyc();
    read_cnt("mrst_cnt2", 16'h0002);
    drain("mrst", 2);
    read_cnt("mrst_end", 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
